// File: rtl/food_spawn_ctrl.sv
// Food placement sequencer: samples the random coordinate source, snaps and range-checks it,
// queries the snake-body occupancy checker and commits the food cell or a fixed fallback.
module food_spawn_ctrl #(
    parameter int GRID       = 10,
    parameter int X_MIN      = 90,
    parameter int X_MAX      = 350,
    parameter int Y_MIN      = 90,
    parameter int Y_MAX      = 350,
    parameter int MAX_TRIES  = 16,
    parameter int FALLBACK_X = 220,
    parameter int FALLBACK_Y = 220
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spawn_req,
    input  logic [9:0] rand_x,
    input  logic [8:0] rand_y,
    output logic       chk_valid,
    output logic [9:0] chk_x,
    output logic [8:0] chk_y,
    input  logic       chk_done,
    input  logic       chk_hit,
    output logic [9:0] food_x,
    output logic [8:0] food_y,
    output logic       food_valid,
    output logic       spawn_done,
    output logic       used_fallbk,
    output logic       busy
);

    localparam int TW = $clog2(MAX_TRIES + 1);

    localparam logic [10:0]   GRID_W = 11'(GRID);
    localparam logic [10:0]   XMIN_W = 11'(X_MIN);
    localparam logic [10:0]   XMAX_W = 11'(X_MAX);
    localparam logic [10:0]   YMIN_W = 11'(Y_MIN);
    localparam logic [10:0]   YMAX_W = 11'(Y_MAX);
    localparam logic [TW-1:0] MAX_T  = TW'(MAX_TRIES);
    localparam logic [9:0]    FB_X   = 10'(FALLBACK_X);
    localparam logic [8:0]    FB_Y   = 9'(FALLBACK_Y);

    typedef enum logic [1:0] {IDLE, SAMPLE, CHECK} state_e;

    state_e        state_q, state_d;
    logic          captured_q, captured_d;
    logic [9:0]    samp_x_q, samp_x_d;
    logic [8:0]    samp_y_q, samp_y_d;
    logic [TW-1:0] tries_q, tries_d;
    logic          chk_valid_q, chk_valid_d;
    logic [9:0]    chk_x_q, chk_x_d;
    logic [8:0]    chk_y_q, chk_y_d;
    logic [9:0]    food_x_q, food_x_d;
    logic [8:0]    food_y_q, food_y_d;
    logic          food_valid_q, food_valid_d;
    logic          spawn_done_q, spawn_done_d;
    logic          used_fb_q, used_fb_d;

    logic [10:0]   rx_w, ry_w, dx, dy;
    logic [9:0]    snap_x;
    logic [8:0]    snap_y;
    logic          x_ok, y_ok, retry;
    logic [TW-1:0] tries_inc;

    // Range check runs on the raw sample; the offset is only formed once it passes.
    assign rx_w   = {1'b0, samp_x_q};
    assign ry_w   = {2'b0, samp_y_q};
    assign x_ok   = (rx_w >= XMIN_W) && (rx_w <= XMAX_W);
    assign y_ok   = (ry_w >= YMIN_W) && (ry_w <= YMAX_W);
    assign dx     = x_ok ? (rx_w - XMIN_W) : '0;
    assign dy     = y_ok ? (ry_w - YMIN_W) : '0;
    assign snap_x = 10'(XMIN_W + (dx / GRID_W) * GRID_W);
    assign snap_y = 9'(YMIN_W + (dy / GRID_W) * GRID_W);

    assign tries_inc = tries_q + TW'(1);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d      = state_q;
        captured_d   = captured_q;
        samp_x_d     = samp_x_q;
        samp_y_d     = samp_y_q;
        tries_d      = tries_q;
        chk_valid_d  = chk_valid_q;
        chk_x_d      = chk_x_q;
        chk_y_d      = chk_y_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        spawn_done_d = 1'b0;
        used_fb_d    = used_fb_q;
        retry        = 1'b0;

        case (state_q)
            IDLE: begin
                if (spawn_req) begin
                    state_d      = SAMPLE;
                    captured_d   = 1'b0;
                    food_valid_d = 1'b0;
                    tries_d      = '0;
                end
            end
            SAMPLE: begin
                if (!captured_q) begin
                    samp_x_d   = rand_x;
                    samp_y_d   = rand_y;
                    captured_d = 1'b1;
                end else begin
                    captured_d = 1'b0;
                    if (x_ok && y_ok) begin
                        chk_x_d     = snap_x;
                        chk_y_d     = snap_y;
                        chk_valid_d = 1'b1;
                        state_d     = CHECK;
                    end else begin
                        retry = 1'b1;
                    end
                end
            end
            CHECK: begin
                if (chk_done) begin
                    chk_valid_d = 1'b0;
                    if (!chk_hit) begin
                        food_x_d     = chk_x_q;
                        food_y_d     = chk_y_q;
                        food_valid_d = 1'b1;
                        spawn_done_d = 1'b1;
                        used_fb_d    = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        retry = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Budget exhausted: commit the fallback cell without querying the checker.
        if (retry) begin
            tries_d = tries_inc;
            if (tries_inc == MAX_T) begin
                food_x_d     = FB_X;
                food_y_d     = FB_Y;
                food_valid_d = 1'b1;
                spawn_done_d = 1'b1;
                used_fb_d    = 1'b1;
                state_d      = IDLE;
            end else begin
                state_d    = SAMPLE;
                captured_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            captured_q   <= 1'b0;
            samp_x_q     <= '0;
            samp_y_q     <= '0;
            tries_q      <= '0;
            chk_valid_q  <= 1'b0;
            chk_x_q      <= '0;
            chk_y_q      <= '0;
            food_x_q     <= FB_X;
            food_y_q     <= FB_Y;
            food_valid_q <= 1'b0;
            spawn_done_q <= 1'b0;
            used_fb_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            captured_q   <= captured_d;
            samp_x_q     <= samp_x_d;
            samp_y_q     <= samp_y_d;
            tries_q      <= tries_d;
            chk_valid_q  <= chk_valid_d;
            chk_x_q      <= chk_x_d;
            chk_y_q      <= chk_y_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            spawn_done_q <= spawn_done_d;
            used_fb_q    <= used_fb_d;
        end
    end

    assign chk_valid   = chk_valid_q;
    assign chk_x       = chk_x_q;
    assign chk_y       = chk_y_q;
    assign food_x      = food_x_q;
    assign food_y      = food_y_q;
    assign food_valid  = food_valid_q;
    assign spawn_done  = spawn_done_q;
    assign used_fallbk = used_fb_q;
    assign busy        = (state_q != IDLE);

endmodule
